// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one floating-point add/subtract unit among N_CH clients.
// One transaction at a time: grant, issue, wait for the adder, hold result until acked, release.
module fpu_addsub_arbiter #(
    parameter int W    = 32,
    parameter int N_CH = 2,
    parameter int ID_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       cli_beg,
    input  logic [N_CH-1:0]       cli_ack,
    input  logic [N_CH-1:0]       cli_op,
    input  logic [2*N_CH-1:0]     cli_rmode,
    input  logic [W*N_CH-1:0]     cli_dataA,
    input  logic [W*N_CH-1:0]     cli_dataB,
    output logic [N_CH-1:0]       cli_ready,
    output logic [W-1:0]          cli_result,
    output logic                  fpu_beg,
    output logic                  fpu_ack,
    output logic                  fpu_op,
    output logic [1:0]            fpu_rmode,
    output logic [W-1:0]          fpu_dataA,
    output logic [W-1:0]          fpu_dataB,
    input  logic                  fpu_ready,
    input  logic [W-1:0]          fpu_result,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]      state_reg, state_next;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] grant_id_reg;
    logic [N_CH-1:0] cli_ready_reg;
    logic [W-1:0]    cli_result_reg;
    logic            fpu_beg_reg, fpu_ack_reg, fpu_op_reg, busy_reg;
    logic [1:0]      fpu_rmode_reg;
    logic [W-1:0]    fpu_data_a_reg, fpu_data_b_reg;

    logic [ID_W:0]   scan_sum   [N_CH];
    logic [ID_W-1:0] scan_idx   [N_CH];
    logic [W-1:0]    ch_data_a  [N_CH];
    logic [W-1:0]    ch_data_b  [N_CH];
    logic [1:0]      ch_rmode   [N_CH];
    logic [N_CH-1:0] grant_onehot;

    logic            req_found;
    logic [ID_W-1:0] req_pick;
    logic            do_grant, do_capture, do_ack;
    logic [ID_W-1:0] ptr_next;

    // Scan position gi is ptr+gi wrapped once; ptr < N_CH keeps the sum below 2*N_CH.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign scan_sum[gi]     = {1'b0, ptr_reg} + (ID_W+1)'(gi);
            assign scan_idx[gi]     = (scan_sum[gi] >= (ID_W+1)'(N_CH))
                                      ? ID_W'(scan_sum[gi] - (ID_W+1)'(N_CH))
                                      : ID_W'(scan_sum[gi]);
            assign ch_data_a[gi]    = cli_dataA[W*gi +: W];
            assign ch_data_b[gi]    = cli_dataB[W*gi +: W];
            assign ch_rmode[gi]     = cli_rmode[2*gi +: 2];
            assign grant_onehot[gi] = (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    // Descending scan so the position closest to ptr wins.
    always_comb begin
        req_found = 1'b0;
        req_pick  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cli_beg[scan_idx[k]]) begin
                req_found = 1'b1;
                req_pick  = scan_idx[k];
            end
        end
    end

    assign do_grant   = (state_reg == S_IDLE) && req_found;
    assign do_capture = (state_reg == S_WAIT) && fpu_ready;
    assign do_ack     = (state_reg == S_HOLD) && cli_ack[grant_id_reg];
    assign ptr_next   = (grant_id_reg == ID_W'(N_CH - 1)) ? '0 : grant_id_reg + ID_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (req_found) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_WAIT;
            S_WAIT:    if (fpu_ready) state_next = S_HOLD;
            S_HOLD:    if (do_ack) state_next = S_RELEASE;
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            grant_id_reg   <= '0;
            cli_ready_reg  <= '0;
            cli_result_reg <= '0;
            fpu_beg_reg    <= 1'b0;
            fpu_ack_reg    <= 1'b0;
            fpu_op_reg     <= 1'b0;
            fpu_rmode_reg  <= '0;
            fpu_data_a_reg <= '0;
            fpu_data_b_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            busy_reg    <= (state_next != S_IDLE);
            fpu_beg_reg <= do_grant;
            fpu_ack_reg <= do_ack;
            if (do_grant) begin
                grant_id_reg   <= req_pick;
                fpu_op_reg     <= cli_op[req_pick];
                fpu_rmode_reg  <= ch_rmode[req_pick];
                fpu_data_a_reg <= ch_data_a[req_pick];
                fpu_data_b_reg <= ch_data_b[req_pick];
            end
            if (do_capture) begin
                cli_result_reg <= fpu_result;
                cli_ready_reg  <= grant_onehot;
            end
            if (do_ack) begin
                cli_ready_reg <= '0;
            end
            if (state_reg == S_RELEASE) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign cli_ready  = cli_ready_reg;
    assign cli_result = cli_result_reg;
    assign fpu_beg    = fpu_beg_reg;
    assign fpu_ack    = fpu_ack_reg;
    assign fpu_op     = fpu_op_reg;
    assign fpu_rmode  = fpu_rmode_reg;
    assign fpu_dataA  = fpu_data_a_reg;
    assign fpu_dataB  = fpu_data_b_reg;
    assign busy       = busy_reg;
    assign grant_id   = grant_id_reg;

endmodule

// File: doc/fpu_addsub_arbiter.md
# fpu_addsub_arbiter

Round-robin arbiter that lets N_CH CORDIC-style clients share one floating-point add/subtract unit through the codebase's beg/ack/ready handshake. It sits between the client coprocessors (beg_add_subt / ack_add_subt / op_add_subt / dataA / dataB) and a single FPU add/subtract instance (beg_FSM / rst_FSM / ready / final_result_ieee). One adder then serves several sine/cosine channels.

## Interface
- W, 32, floating-point word width (32 single, 64 double)
- N_CH, 2, number of client channels, 2..8
- ID_W, 1, grant index width; N_CH <= 2**ID_W
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cli_beg  in  N_CH  per-channel request level; held until that channel's cli_ready
- cli_ack  in  N_CH  per-channel acknowledge of result
- cli_op  in  N_CH  per-channel operation, 0 add / 1 subtract
- cli_rmode  in  2*N_CH  per-channel rounding mode, channel i at [2i+1:2i]
- cli_dataA  in  W*N_CH  operand A, channel i at [W*i+W-1:W*i]
- cli_dataB  in  W*N_CH  operand B, same packing
- cli_ready  out  N_CH  one-hot result-valid, only granted bit set
- cli_result  out  W  registered result, shared by all channels
- fpu_beg  out  1  start pulse to adder
- fpu_ack  out  1  result-received pulse to adder (drives its rst_FSM)
- fpu_op, fpu_rmode, fpu_dataA, fpu_dataB  out  1/2/W/W  latched operands of granted channel
- fpu_ready  in  1  adder done
- fpu_result  in  W  adder result
- busy  out  1  high in every state except IDLE
- grant_id  out  ID_W  index of channel being served

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, RELEASE.
- IDLE: if any cli_beg is set, select the first requester scanning ptr, ptr+1, … mod N_CH. Latch its op, rmode, dataA and dataB into fpu_* registers. Set grant_id. Go to ISSUE. No request: stay.
- ISSUE: fpu_beg=1 for exactly this cycle. Go to WAIT.
- WAIT: fpu_ready is sampled here only. On fpu_ready=1: capture fpu_result into cli_result, go to HOLD.
- HOLD: cli_ready[grant_id]=1, held. On cli_ack[grant_id]=1: go to RELEASE.
- RELEASE: fpu_ack=1 for exactly this cycle, cli_ready=0. ptr <= (grant_id+1) mod N_CH. Go to IDLE.
- A granted transaction is committed. If the client drops cli_beg after grant, the operation still completes and the result still waits for cli_ack.
- cli_ack from a non-granted channel, or in any state but HOLD: ignored.
- fpu_ready in IDLE, ISSUE, HOLD or RELEASE: ignored.
- cli_beg withdrawn while in IDLE before being sampled: no grant.
- Operand latching uses registered copies. Client data may change after the grant cycle.
- cli_result keeps its last value until the next capture.
- Reset values: state IDLE, ptr 0, grant_id 0, every output 0 including cli_result and fpu_data*.
- rst in any state, including mid-WAIT, forces reset values on the next edge. The shared adder takes the same rst, so no fpu_ack is issued. Pending requests are re-arbitrated from channel 0.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: ISSUE, fpu_beg=1, fpu_data* valid.
- From cycle 2: WAIT.
- If fpu_ready is first high in cycle k: HOLD and cli_ready from k+1, with cli_result valid in the same cycle.
- If cli_ack is high in HOLD cycle m: RELEASE (fpu_ack=1) in m+1, IDLE in m+2.
- The earliest next grant is sampled in cycle m+2.
- Arbitration overhead per transaction: 4 cycles plus the adder latency plus the client ack delay.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> all outputs 0, busy 0, grant_id 0.
- Single request:
  - Stimulus: N_CH=2, ch0 beg with A=0x3F800000, B=0x40000000, op=0. Adder model returns 0x40400000 with fpu_ready 5 cycles after fpu_beg. Ch0 acks 2 cycles after its cli_ready.
  - Response: fpu_beg in cycle 1, cli_ready=2'b01 with cli_result=0x40400000, fpu_ack one cycle after the ack, busy falls after RELEASE.
- Contention and wrap, N_CH=4:
  - Stimulus: ch3 and ch0 request together from reset, then re-request immediately after each is served.
  - Response: grant order 0,3,0,3. Ptr wraps from 3 to 0 after serving ch3.
- Illegal acks:
  - Stimulus: ch0 served; ch1 asserts cli_ack during HOLD, and ch0 asserts cli_ack during WAIT.
  - Response: both ignored; the FSM stays in HOLD until ch0 acks in HOLD.
- Reset mid-operation:
  - Stimulus: rst in the 3rd WAIT cycle while ch1 is also requesting.
  - Response: next cycle all outputs 0 and no fpu_ack. After rst is released, ch0 (if still requesting) is granted before ch1.
- Withdrawn and committed requests:
  - Stimulus: ch1 pulses beg for one cycle while the FSM is in WAIT serving ch0.
  - Response: ch1 is never granted.
  - Stimulus: ch1 drops beg one cycle after its grant.
  - Response: the transaction completes, and cli_ready[1] asserts and is held until ch1 acks.
